// File: rtl/exmem_pkg.sv
// exmem_pkg: shared payload layout and constants for the EX/MEM stage.
// Payload packs {wreg, m2reg, wmem, temp, r, qb} from MSB to LSB.
package exmem_pkg;

    localparam int CTRL_W     = 3;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;
    localparam int REG_ZERO   = 0;

    function automatic int pl_w(input int dw, input int rn);
        return CTRL_W + rn + 2 * dw;
    endfunction

    function automatic int off_r(input int dw);
        return dw;
    endfunction

    function automatic int off_temp(input int dw);
        return 2 * dw;
    endfunction

    function automatic int off_wmem(input int dw, input int rn);
        return 2 * dw + rn;
    endfunction

    function automatic int off_m2reg(input int dw, input int rn);
        return 2 * dw + rn + 1;
    endfunction

    function automatic int off_wreg(input int dw, input int rn);
        return 2 * dw + rn + 2;
    endfunction

    function automatic bit stages_ok(input int s);
        return (s >= STAGES_MIN) && (s <= STAGES_MAX);
    endfunction

endpackage

// File: rtl/exmem_pipe_slice.sv
// pipe_slice: one register slice of the EX/MEM pipe.
// Payload only moves on a valid source so a bubble leaves stale contents.
module pipe_slice
    import exmem_pkg::*;
#(
    parameter int PL_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            load,
    input  logic            src_valid,
    input  logic [PL_W-1:0] src_pl,
    output logic            valid,
    output logic [PL_W-1:0] pl
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            pl    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= src_valid;
            if (src_valid)
                pl <= src_pl;
        end
    end

endmodule

// File: rtl/exmem_pipe.sv
// exmem_pipe: multi-slice EX/MEM register with handshake, flush and
// a combinational forwarding query for the hazard unit.
module exmem_pipe
    import exmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RN_W   = 5,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              e_valid,
    output logic              e_ready,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic              ewmem,
    input  logic [RN_W-1:0]   etemp,
    input  logic [DATA_W-1:0] r,
    input  logic [DATA_W-1:0] eqb,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              mwreg,
    output logic              mm2reg,
    output logic              mwmem,
    output logic [RN_W-1:0]   mtemp,
    output logic [DATA_W-1:0] mr,
    output logic [DATA_W-1:0] mqb,
    input  logic [RN_W-1:0]   q_rn,
    output logic              q_hit,
    output logic              q_load,
    output logic [DATA_W-1:0] q_data
);

    localparam int PL_W = pl_w(DATA_W, RN_W);
    localparam int O_R  = off_r(DATA_W);
    localparam int O_T  = off_temp(DATA_W);
    localparam int O_WM = off_wmem(DATA_W, RN_W);
    localparam int O_M2 = off_m2reg(DATA_W, RN_W);
    localparam int O_WR = off_wreg(DATA_W, RN_W);

    if (!stages_ok(STAGES)) begin : g_bad_stages
        $error("exmem_pipe: STAGES out of range");
    end

    logic            v  [STAGES];
    logic [PL_W-1:0] pl [STAGES];
    logic [STAGES-1:0] ml;
    logic [PL_W-1:0] e_pl;
    logic [PL_W-1:0] opl;

    assign e_pl = {ewreg, em2reg, ewmem, etemp, r, eqb};

    // A slice may load if empty or if everything downstream moves.
    always_comb begin
        ml = '0;
        ml[STAGES-1] = ~v[STAGES-1] | m_ready;
        for (int i = STAGES - 2; i >= 0; i--)
            ml[i] = ~v[i] | ml[i+1];
    end

    assign e_ready = ml[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_sl
        logic            sv;
        logic [PL_W-1:0] spl;
        if (i == 0) begin : g_head
            assign sv  = e_valid;
            assign spl = e_pl;
        end else begin : g_body
            assign sv  = v[i-1];
            assign spl = pl[i-1];
        end
        pipe_slice #(.PL_W(PL_W)) u_slice (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .load      (ml[i]),
            .src_valid (sv),
            .src_pl    (spl),
            .valid     (v[i]),
            .pl        (pl[i])
        );
    end

    assign opl     = pl[STAGES-1];
    assign m_valid = v[STAGES-1];
    assign mwreg   = m_valid & opl[O_WR];
    assign mwmem   = m_valid & opl[O_WM];
    assign mm2reg  = opl[O_M2];
    assign mtemp   = opl[O_T +: RN_W];
    assign mr      = opl[O_R +: DATA_W];
    assign mqb     = opl[DATA_W-1:0];

    // Scan oldest to newest so the newest match overrides.
    always_comb begin
        q_hit  = 1'b0;
        q_load = 1'b0;
        q_data = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (v[i] && pl[i][O_WR] &&
                pl[i][O_T +: RN_W] == q_rn &&
                q_rn != RN_W'(REG_ZERO)) begin
                q_hit  = 1'b1;
                q_load = pl[i][O_M2];
                q_data = pl[i][O_R +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_exmem_pipe.sv
// tb_exmem_pipe: directed scenarios plus randomized queue-model checks
// on two instances (STAGES=2 and STAGES=3) sharing one stimulus bus.
module tb_exmem_pipe;

    typedef struct {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [4:0]  temp;
        logic [31:0] r;
        logic [31:0] qb;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, e_valid, ewreg, em2reg, ewmem, m_ready;
    logic [4:0]  etemp, q_rn;
    logic [31:0] r, eqb;

    logic        e_rdy   [2:3];
    logic        m_v     [2:3];
    logic        mwreg_o [2:3];
    logic        mm2reg_o[2:3];
    logic        mwmem_o [2:3];
    logic        qhit    [2:3];
    logic        qload   [2:3];
    logic [4:0]  mtemp_o [2:3];
    logic [31:0] mr_o    [2:3];
    logic [31:0] mqb_o   [2:3];
    logic [31:0] qdata   [2:3];

    int errors = 0;
    int checks = 0;

    exmem_pipe #(.DATA_W(32), .RN_W(5), .STAGES(2)) u2 (
        .clk(clk), .rst(rst), .flush(flush),
        .e_valid(e_valid), .e_ready(e_rdy[2]),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .etemp(etemp), .r(r), .eqb(eqb),
        .m_valid(m_v[2]), .m_ready(m_ready),
        .mwreg(mwreg_o[2]), .mm2reg(mm2reg_o[2]), .mwmem(mwmem_o[2]),
        .mtemp(mtemp_o[2]), .mr(mr_o[2]), .mqb(mqb_o[2]),
        .q_rn(q_rn), .q_hit(qhit[2]), .q_load(qload[2]), .q_data(qdata[2])
    );

    exmem_pipe #(.DATA_W(32), .RN_W(5), .STAGES(3)) u3 (
        .clk(clk), .rst(rst), .flush(flush),
        .e_valid(e_valid), .e_ready(e_rdy[3]),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .etemp(etemp), .r(r), .eqb(eqb),
        .m_valid(m_v[3]), .m_ready(m_ready),
        .mwreg(mwreg_o[3]), .mm2reg(mm2reg_o[3]), .mwmem(mwmem_o[3]),
        .mtemp(mtemp_o[3]), .mr(mr_o[3]), .mqb(mqb_o[3]),
        .q_rn(q_rn), .q_hit(qhit[3]), .q_load(qload[3]), .q_data(qdata[3])
    );

    task automatic idle();
        e_valid = 1'b0;
        flush   = 1'b0;
        ewreg   = 1'b0;
        em2reg  = 1'b0;
        ewmem   = 1'b0;
        etemp   = '0;
        r       = '0;
        eqb     = '0;
    endtask

    task automatic put(input logic wr, input logic m2, input logic wm,
                       input logic [4:0] t, input logic [31:0] rv,
                       input logic [31:0] qb);
        e_valid = 1'b1;
        ewreg   = wr;
        em2reg  = m2;
        ewmem   = wm;
        etemp   = t;
        r       = rv;
        eqb     = qb;
    endtask

    // Ends at a negedge with state cleared and rst released.
    task automatic do_reset();
        @(negedge clk);
        idle();
        m_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        m_ready = 1'b1;
        q_rn = 5'd3;
        put(1'b1, 1'b0, 1'b0, 5'd3, 32'h10, 32'h20);
        @(negedge clk);
        #1;
        checks++;
        if (m_v[2] !== 1'b0 || mwreg_o[2] !== 1'b0 || mm2reg_o[2] !== 1'b0 ||
            mwmem_o[2] !== 1'b0)
            begin errors++; $display("FAIL reset_ctrl: got v=%b w=%b l=%b m=%b required 0",
                m_v[2], mwreg_o[2], mm2reg_o[2], mwmem_o[2]); end
        checks++;
        if (mtemp_o[2] !== 5'd0 || mr_o[2] !== 32'd0 || mqb_o[2] !== 32'd0)
            begin errors++; $display("FAIL reset_payload: got t=%0h r=%0h qb=%0h required 0",
                mtemp_o[2], mr_o[2], mqb_o[2]); end
        checks++;
        if (qhit[2] !== 1'b0 || e_rdy[2] !== 1'b1)
            begin errors++; $display("FAIL reset_hs: got q_hit=%b e_ready=%b required 0/1",
                qhit[2], e_rdy[2]); end
        rst = 1'b0;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (m_v[2] !== 1'b0 || m_v[3] !== 1'b0)
            begin errors++; $display("FAIL latency_early: got %b/%b required 0/0",
                m_v[2], m_v[3]); end
        @(negedge clk);
        #1;
        checks++;
        if (m_v[2] !== 1'b1 || mtemp_o[2] !== 5'd3 || mr_o[2] !== 32'h10 ||
            mqb_o[2] !== 32'h20 || mwreg_o[2] !== 1'b1)
            begin errors++; $display("FAIL latency_s2: got v=%b t=%0h r=%0h qb=%0h required 1/3/10/20",
                m_v[2], mtemp_o[2], mr_o[2], mqb_o[2]); end
        checks++;
        if (m_v[3] !== 1'b0)
            begin errors++; $display("FAIL latency_s3_early: got %b required 0", m_v[3]); end
        @(negedge clk);
        #1;
        checks++;
        if (m_v[3] !== 1'b1 || mr_o[3] !== 32'h10)
            begin errors++; $display("FAIL latency_s3: got v=%b r=%0h required 1/10",
                m_v[3], mr_o[3]); end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        int nv;
        bit stalled;
        nv = 1;
        stalled = 0;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            m_ready = !(c >= 3 && c <= 5);
            if (nv <= 6) put(1'b1, 1'b0, 1'b0, 5'd1, 32'(nv), 32'h0);
            else idle();
            #1;
            if (m_v[2] === 1'b1 && m_ready) got.push_back(mr_o[2]);
            if (e_rdy[2] !== 1'b1) stalled = 1;
            if (e_valid && e_rdy[2] === 1'b1) nv++;
            @(negedge clk);
        end
        checks++;
        if (!stalled)
            begin errors++; $display("FAIL bp_stall: got e_ready never low required a drop"); end
        checks++;
        if (got.size() != 6)
            begin errors++; $display("FAIL bp_count: got %0d required 6", got.size()); end
        for (int k = 0; k < got.size() && k < 6; k++) begin
            checks++;
            if (got[k] !== 32'(k + 1))
                begin errors++; $display("FAIL bp_order[%0d]: got %0h required %0h",
                    k, got[k], k + 1); end
        end
    endtask

    task automatic test_flush();
        bit seen;
        seen = 0;
        do_reset();
        put(1'b1, 1'b0, 1'b1, 5'd4, 32'h41, 32'h1);
        @(negedge clk);
        put(1'b1, 1'b0, 1'b1, 5'd4, 32'h42, 32'h2);
        @(negedge clk);
        put(1'b1, 1'b0, 1'b1, 5'd4, 32'h99, 32'h3);
        flush = 1'b1;
        q_rn = 5'd4;
        #1;
        checks++;
        if (qhit[2] !== 1'b1 || qdata[2] !== 32'h42)
            begin errors++; $display("FAIL flush_pre_fwd: got hit=%b data=%0h required 1/42",
                qhit[2], qdata[2]); end
        @(negedge clk);
        idle();
        m_ready = 1'b1;
        #1;
        checks++;
        if (m_v[2] !== 1'b0 || mwmem_o[2] !== 1'b0 || qhit[2] !== 1'b0)
            begin errors++; $display("FAIL flush_clear: got v=%b wmem=%b hit=%b required 0",
                m_v[2], mwmem_o[2], qhit[2]); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (m_v[2] === 1'b1 && mr_o[2] === 32'h99) seen = 1;
        end
        checks++;
        if (seen)
            begin errors++; $display("FAIL flush_leak: got 99 at output required never"); end
    endtask

    task automatic test_forward_priority();
        do_reset();
        put(1'b1, 1'b0, 1'b0, 5'd5, 32'hB, 32'h0);
        @(negedge clk);
        put(1'b1, 1'b0, 1'b0, 5'd7, 32'h77, 32'h0);
        @(negedge clk);
        put(1'b1, 1'b1, 1'b0, 5'd5, 32'hA, 32'h0);
        @(negedge clk);
        idle();
        q_rn = 5'd5;
        #1;
        checks++;
        if (qhit[3] !== 1'b1 || qload[3] !== 1'b1 || qdata[3] !== 32'hA)
            begin errors++; $display("FAIL fwd_newest: got %b/%b/%0h required 1/1/a",
                qhit[3], qload[3], qdata[3]); end
        q_rn = 5'd7;
        #1;
        checks++;
        if (qhit[3] !== 1'b1 || qload[3] !== 1'b0 || qdata[3] !== 32'h77)
            begin errors++; $display("FAIL fwd_mid: got %b/%b/%0h required 1/0/77",
                qhit[3], qload[3], qdata[3]); end
        q_rn = 5'd0;
        #1;
        checks++;
        if (qhit[3] !== 1'b0 || qload[3] !== 1'b0 || qdata[3] !== 32'h0)
            begin errors++; $display("FAIL fwd_r0: got %b/%b/%0h required 0/0/0",
                qhit[3], qload[3], qdata[3]); end
        checks++;
        if (e_rdy[3] !== 1'b0 || m_v[3] !== 1'b1 || mr_o[3] !== 32'hB)
            begin errors++; $display("FAIL full_stall: got rdy=%b v=%b r=%0h required 0/1/b",
                e_rdy[3], m_v[3], mr_o[3]); end
        m_ready = 1'b1;
        put(1'b1, 1'b0, 1'b0, 5'd9, 32'hC, 32'h0);
        #1;
        checks++;
        if (e_rdy[3] !== 1'b1)
            begin errors++; $display("FAIL full_drain_rdy: got %b required 1", e_rdy[3]); end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (m_v[3] !== 1'b1 || mr_o[3] !== 32'h77)
            begin errors++; $display("FAIL full_drain_next: got v=%b r=%0h required 1/77",
                m_v[3], mr_o[3]); end
    endtask

    task automatic test_bubble();
        do_reset();
        m_ready = 1'b1;
        put(1'b1, 1'b1, 1'b1, 5'd6, 32'h55, 32'h66);
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        checks++;
        if (m_v[2] !== 1'b1 || mwmem_o[2] !== 1'b1)
            begin errors++; $display("FAIL bubble_pre: got v=%b wmem=%b required 1/1",
                m_v[2], mwmem_o[2]); end
        @(negedge clk);
        #1;
        checks++;
        if (m_v[2] !== 1'b0 || mwmem_o[2] !== 1'b0 || mwreg_o[2] !== 1'b0)
            begin errors++; $display("FAIL bubble_qual: got v=%b wmem=%b wreg=%b required 0",
                m_v[2], mwmem_o[2], mwreg_o[2]); end
        checks++;
        if (mr_o[2] !== 32'h55 || mm2reg_o[2] !== 1'b1)
            begin errors++; $display("FAIL bubble_raw: got r=%0h m2reg=%b required 55/1",
                mr_o[2], mm2reg_o[2]); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        put(1'b1, 1'b0, 1'b1, 5'd2, 32'h1, 32'h0);
        @(negedge clk);
        put(1'b1, 1'b0, 1'b1, 5'd2, 32'h2, 32'h0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (m_v[2] !== 1'b0 || e_rdy[2] !== 1'b1)
            begin errors++; $display("FAIL reset_stall: got v=%b rdy=%b required 0/1",
                m_v[2], e_rdy[2]); end
    endtask

    // In-flight entries as an ordered queue: front is at the memory stage.
    task automatic test_random(input int s, input int n);
        ent_t q[$];
        ent_t e;
        logic exp_rdy, ehit, eload, acc, pop, fl;
        logic [31:0] edata;
        do_reset();
        for (int c = 0; c < n; c++) begin
            e_valid = ($urandom_range(0, 3) != 0);
            ewreg   = 1'($urandom_range(0, 1));
            em2reg  = 1'($urandom_range(0, 1));
            ewmem   = 1'($urandom_range(0, 1));
            etemp   = 5'($urandom_range(0, 7));
            r       = $urandom;
            eqb     = $urandom;
            m_ready = ($urandom_range(0, 9) < 6);
            flush   = ($urandom_range(0, 29) == 0);
            q_rn    = 5'($urandom_range(0, 7));
            #1;
            exp_rdy = (q.size() < s) || m_ready;
            checks++;
            if (e_rdy[s] !== exp_rdy)
                begin errors++; $display("FAIL rnd%0d_rdy c=%0d: got %b required %b",
                    s, c, e_rdy[s], exp_rdy); end
            checks++;
            if (m_v[s] === 1'b1) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd%0d_spurious c=%0d: got m_valid=1 required 0", s, c);
                end else if (mr_o[s] !== q[0].r || mqb_o[s] !== q[0].qb ||
                             mtemp_o[s] !== q[0].temp || mm2reg_o[s] !== q[0].m2reg ||
                             mwreg_o[s] !== q[0].wreg || mwmem_o[s] !== q[0].wmem) begin
                    errors++;
                    $display("FAIL rnd%0d_out c=%0d: got r=%0h t=%0h required r=%0h t=%0h",
                        s, c, mr_o[s], mtemp_o[s], q[0].r, q[0].temp);
                end
            end else if (m_v[s] === 1'b0) begin
                if (q.size() == s || mwreg_o[s] !== 1'b0 || mwmem_o[s] !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd%0d_idle c=%0d: got v=0 w=%b m=%b with %0d queued",
                        s, c, mwreg_o[s], mwmem_o[s], q.size());
                end
            end else begin
                errors++;
                $display("FAIL rnd%0d_x c=%0d: got m_valid=%b required 0/1", s, c, m_v[s]);
            end
            ehit = 1'b0;
            eload = 1'b0;
            edata = '0;
            for (int k = 0; k < q.size(); k++) begin
                if (q[k].wreg && q[k].temp == q_rn && q_rn != 5'd0) begin
                    ehit = 1'b1;
                    eload = q[k].m2reg;
                    edata = q[k].r;
                end
            end
            checks++;
            if (qhit[s] !== ehit || qload[s] !== eload || qdata[s] !== edata)
                begin errors++; $display("FAIL rnd%0d_fwd c=%0d: got %b/%b/%0h required %b/%b/%0h",
                    s, c, qhit[s], qload[s], qdata[s], ehit, eload, edata); end
            e = '{wreg: ewreg, m2reg: em2reg, wmem: ewmem, temp: etemp, r: r, qb: eqb};
            fl  = flush;
            acc = e_valid && exp_rdy && !flush;
            pop = (m_v[s] === 1'b1) && m_ready && (q.size() > 0);
            @(posedge clk);
            if (fl) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        rst = 1'b0;
        m_ready = 1'b0;
        q_rn = '0;
        idle();
        test_reset();
        test_backpressure();
        test_flush();
        test_forward_priority();
        test_bubble();
        test_reset_mid_stall();
        test_random(2, 400);
        test_random(3, 400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exmem_pipe.md
# exmem_pipe

Parametrised EX/MEM pipeline stage for the mini-CPU. It carries the execute-stage result, store data, destination register and memory/write-back control into the memory stage. Unlike a plain clocked register, it has a configurable number of register slices and a valid/ready handshake for stalls. It also supports flush for branch/exception squash, plus a combinational forwarding-query port for the hazard unit.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and store data
- RN_W, 5, register-number width
- STAGES, 1, number of register slices (legal range 1..4)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous squash of all in-flight entries
- e_valid  in  1  execute stage presents an entry
- e_ready  out  1  stage accepts the entry this cycle
- ewreg  in  1  entry writes register file
- em2reg  in  1  entry is a load (write-back from memory)
- ewmem  in  1  entry writes memory
- etemp  in  RN_W  destination register number
- r  in  DATA_W  ALU result / memory address
- eqb  in  DATA_W  store data
- m_valid  out  1  oldest entry valid at memory stage
- m_ready  in  1  memory stage consumes the oldest entry
- mwreg, mm2reg, mwmem  out  1 each  control of oldest entry
- mtemp  out  RN_W; mr, mqb  out  DATA_W  payload of oldest entry
- q_rn  in  RN_W  forwarding query register number
- q_hit  out  1  an in-flight entry will write q_rn
- q_load  out  1  the matching entry is a load (data not yet available)
- q_data  out  DATA_W  r field of the matching entry

## Operation
- Slices are numbered 0 (newest) to STAGES-1 (oldest). Each slice holds a valid bit and a payload {wreg, m2reg, wmem, temp, r, qb}.
- Slice STAGES-1 drives the m_* outputs.
- Slice advance rule:
  - Slice i may load when it is empty, or when it advances this cycle.
  - The oldest slice advances when m_valid && m_ready.
  - Slice i < STAGES-1 advances when it is valid and slice i+1 may load.
- e_ready equals "slice 0 may load". The ready chain is combinational from m_ready; there is no skid buffer.
- Accept: e_valid && e_ready loads the input into slice 0 with valid=1.
- Bubbles: if a slice may load but its upstream source is empty, its valid bit becomes 0.
- Qualified controls: mwreg and mwmem are ANDed with m_valid, so a bubble never writes. mm2reg, mtemp, mr and mqb are raw slice contents.
- Flush: clears every valid bit. The input offered in the same cycle is not captured. Payload registers hold their values.
- Priority: rst > flush > normal advance.
- Forwarding query:
  - A slice matches when valid && wreg && temp==q_rn && q_rn!=0.
  - The newest matching slice wins.
  - q_hit = any match. q_load = winner.m2reg. q_data = winner.r.
  - With no match: q_hit=0, q_load=0, q_data=0.
  - The query is purely combinational and does not depend on e_* or m_ready.

## Timing
- Reset (synchronous, rst=1 at clk edge): all valid bits and all payload registers clear to 0. After reset, m_valid=0, mwreg=mm2reg=mwmem=0, mtemp=0, mr=mqb=0, and q_hit=0. Under reset with all slices empty, e_ready=1.
- Latency: an entry accepted at edge N appears on m_* after edge N+STAGES-1, i.e. STAGES cycles from input to memory-stage register. This assumes no backpressure.
- Throughput: one entry per cycle while m_ready=1.
- Full and draining (all slices valid, m_ready=1): e_ready=1. Accept and drain happen in the same edge, with no bubble.
- Full and stalled (all slices valid, m_ready=0): e_ready=0 and all slices hold.
- Partial stall: empty slices below a stalled slice still fill (bubbles collapse).
- Flush together with m_ready=1: the oldest entry is considered consumed by the memory stage this cycle. After the edge, all slices are empty.
- Reset mid-stall discards all entries. m_valid=0 on the next cycle.

## Structure
- A shared package/header exmem_pkg holds:
  - payload field widths and bit offsets (PL_W = 3 + RN_W + 2*DATA_W)
  - the STAGES legal-range check constant
  - the register-0 constant used by the forwarding match
- One sub-module, pipe_slice: valid bit plus PL_W-wide payload register, with load/advance/flush/rst logic. It is instantiated STAGES times in a generate loop.
- The forwarding priority mux stays in the top module.

## Test plan
- Reset/latency, STAGES=2: assert rst, then issue {ewreg=1, etemp=3, r=0x10, eqb=0x20} with m_ready=1 → m_* all 0 during reset; entry shows m_valid=1, mtemp=3, mr=0x10, mqb=0x20 two cycles after acceptance.
- Backpressure, STAGES=2: stream entries r=1..6 with m_ready low for cycles 3–5 → e_ready drops once both slices are full; output order is 1..6 with no loss or duplication; each accepted entry appears exactly once with m_valid=1.
- Flush: two entries in flight, pulse flush with e_valid=1 (r=0x99) → next cycle m_valid=0, mwmem=0, q_hit=0; r=0x99 never appears at the output.
- Forwarding priority, STAGES=3: slice 0 holds {temp=5, r=0xA, m2reg=1} and slice 2 holds {temp=5, r=0xB} → q_rn=5 gives q_hit=1, q_load=1, q_data=0xA; q_rn=0 gives q_hit=0.
- Bubble write suppression: m_valid=0 with a stale payload holding wmem=1 → mwmem=0 and mwreg=0.
